serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Sequences a single 1-bit full-adder cell LSB-first over WIDTH cycles, then presents sum and carry-out over a valid/ready handshake.
- Trades latency for area; it is the serial counterpart to the team's combinational full adders, for area-constrained datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-cycle counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  controller can accept operands; high only in IDLE and never while rst is high.
- a  input  WIDTH  operand A; sampled on accept only.
- b  input  WIDTH  operand B; sampled on accept only.
- cin  input  1  carry-in; sampled on accept only.
- out_valid  output  1  sum/cout valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; shift regs, carry and counter cleared; sum=0, cout=0, out_valid=0, busy=0, in_ready=0. in_ready returns to 1 in the first cycle after rst deasserts.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid && in_ready (the accept edge):
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0;
  - sum_sr is not cleared; it is fully overwritten in RUN.
- RUN, per edge:
  - bit s = a_sr[0]^b_sr[0]^carry;
  - c = majority(a_sr[0], b_sr[0], carry), computed by the full-adder cell;
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}; a_sr, b_sr shift right by 1; carry <= c; cnt <= cnt+1.
- RUN -> DONE on the edge where cnt==WIDTH-1:
  - that edge also performs the final bit step;
  - sum <= final sum_sr value and cout <= final carry are registered on the same edge.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. WIDTH=1 means one RUN cycle.
- DONE: out_valid=1; sum and cout held stable until out_valid && out_ready.
  - DONE -> IDLE on that edge; out_valid falls on the same edge.
- IDLE after DONE: sum and cout retain the last result (not cleared).
- in_valid outside IDLE: ignored; in_ready=0. No operand buffering, no overlap between operations.
- Back-to-back: out_ready in DONE and in_valid in the same cycle → return to IDLE. Accept happens on the next edge, so max throughput is one operation per WIDTH+2 cycles.
- a, b, cin changing during RUN/DONE have no effect.
- Reset mid-RUN or mid-DONE: operation discarded, no partial result emitted, out_valid drops immediately (async).
- Width rules:
  - sum = (a+b+cin)[WIDTH-1:0], cout = (a+b+cin)[WIDTH], unsigned;
  - cnt never exceeds WIDTH-1 and has no wrap path.
- in_ready, out_valid and busy decode from the state register only; no combinational paths from inputs to outputs.

Decomposition:
- Shared package/include serial_add_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the CNT_W derivation.
- Sub-module fa_bit_cell (inputs x, y, ci; outputs s, co; purely combinational 1-bit full adder), instantiated once. The controller holds the FSM, counter, shift registers and carry flop.

Test Plan:
- Basic add, WIDTH=8: a=8'h3C, b=8'h0F, cin=0 → out_valid rises exactly 8 edges after accept; sum=8'h4B, cout=0.
- Carry ripple and full carry, WIDTH=8:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1;
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b → sum, cout, out_valid stable; in_ready=0; no new accept. Release → one handshake, then IDLE.
- Reset mid-op: assert rst at cnt=3 of a=8'hAA+b=8'h55 → out_valid=0, busy=0 immediately. After release, a=8'h01, b=8'h02, cin=1 → sum=8'h04, cout=0.
- Back-to-back with in_valid held high, two ops 8'h10+8'h20 and 8'h80+8'h80:
  - results 8'h30/cout 0, then 8'h00/cout 1;
  - second accept exactly one cycle after the first output handshake.
- WIDTH=1 build: a=1, b=1, cin=1 → out_valid one edge after accept, sum=1, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Contents:
//   state_t   - controller state encoding (IDLE / RUN / DONE)
//   cnt_width - width of the bit-cycle counter for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-cycle counter width: enough to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic cell that the
// serial controller reuses on every bit cycle.
// Ports:
//   x, y  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out (majority of x, y, ci)
module fa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Accepts a, b, cin on a valid/ready handshake,
// runs one full-adder cell LSB-first for WIDTH cycles, then presents the
// registered sum and carry-out on a valid/ready handshake.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready high only in IDLE)
//   a, b, cin           - operands, sampled on the accept edge only
//   out_valid, out_ready- result handshake (out_valid high only in DONE)
//   sum, cout           - registered result, held until consumed and after
//   busy                - high while an operation is in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_nxt_s;
  logic             out_valid_nxt_s;
  logic             busy_nxt_s;

  logic             accept_s;
  logic             last_bit_s;
  logic             fa_s_s;
  logic             fa_co_s;

  // Shift helpers built by concatenation so that WIDTH=1 needs no empty slice.
  logic [WIDTH:0]   a_cat_s;
  logic [WIDTH:0]   b_cat_s;
  logic [WIDTH:0]   sum_cat_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [WIDTH-1:0] sum_next_s;

  // in_ready_r is only ever set while the state is IDLE, so it qualifies accept.
  assign accept_s   = in_valid & in_ready_r;
  assign last_bit_s = (cnt_r == CNT_LAST);

  assign a_cat_s    = {1'b0, a_sr_r};
  assign b_cat_s    = {1'b0, b_sr_r};
  assign sum_cat_s  = {fa_s_s, sum_sr_r};
  assign a_shift_s  = a_cat_s[WIDTH:1];
  assign b_shift_s  = b_cat_s[WIDTH:1];
  assign sum_next_s = sum_cat_s[WIDTH:1];

  fa_bit_cell u_fa (
    .x  (a_sr_r[0]),
    .y  (b_sr_r[0]),
    .ci (carry_r),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_valid_r & out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state; registered below so that the
  // handshake flags always match state_r without any input-to-output path.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        in_ready_nxt_s = 1'b1;
      end
      ST_RUN: begin
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        out_valid_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      default: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
    endcase
  end

  // Handshake flag registers; cleared in reset so in_ready stays low until the
  // first edge after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Operand load, bit-serial shift/carry and final result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      sum_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          a_sr_r   <= a_shift_s;
          b_sr_r   <= b_shift_s;
          sum_sr_r <= sum_next_s;
          carry_r  <= fa_co_s;
          if (last_bit_s) begin
            // Final bit: publish the result; counter parks at zero, never wraps.
            sum_r  <= sum_next_s;
            cout_r <= fa_co_s;
            cnt_r  <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance,
// expected results from plain integer addition pushed on accept, popped and
// compared by a monitor when the DUT presents its result.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv8, ir8, cin8, ov8, or8, cout8, busy8;
  logic [W-1:0] a8, b8, sum8;
  logic         iv1, ir1, cin1, ov1, or1, cout1, busy1;
  logic [0:0]   a1, b1, sum1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { logic [W:0] res; int acc; } exp8_t;
  typedef struct { logic [1:0] res; int acc; } exp1_t;
  exp8_t q8[$];
  exp1_t q1[$];
  exp8_t e8;
  exp1_t e1;
  logic  pov8 = 1'b0;
  logic  pov1 = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
    .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // Monitor / scoreboard: compare on result presentation, record accepts.
  always @(negedge clk) begin
    if (rst) begin
      pov8 = 1'b0;
      pov1 = 1'b0;
    end else begin
      if (ov8 && !pov8) begin
        if (q8.size() == 0) begin
          tests++; fails++;
          $display("FAIL out8_unexpected: got %0h with no pending op", {cout8, sum8});
        end else begin
          chk("lat8", (W+1)'(cyc - q8[0].acc), (W+1)'(W));
          chk("res8_rise", {cout8, sum8}, q8[0].res);
        end
      end
      if (ov8 && or8 && q8.size() != 0) begin
        chk("res8_hs", {cout8, sum8}, q8[0].res);
        void'(q8.pop_front());
      end
      chk("excl8", {{W{1'b0}}, ir8 & (busy8 | ov8)}, '0);
      pov8 = ov8;
      if (iv8 && ir8) begin
        e8.res = {1'b0, a8} + {1'b0, b8} + {{W{1'b0}}, cin8};
        e8.acc = cyc + 1;
        q8.push_back(e8);
      end

      if (ov1 && !pov1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL out1_unexpected: got %0h with no pending op", {cout1, sum1});
        end else begin
          chk("lat1", (W+1)'(cyc - q1[0].acc), (W+1)'(1));
          chk("res1_rise", {7'd0, cout1, sum1}, {7'd0, q1[0].res});
        end
      end
      if (ov1 && or1 && q1.size() != 0) begin
        chk("res1_hs", {7'd0, cout1, sum1}, {7'd0, q1[0].res});
        void'(q1.pop_front());
      end
      pov1 = ov1;
      if (iv1 && ir1) begin
        e1.res = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
        e1.acc = cyc + 1;
        q1.push_back(e1);
      end
    end
  end

  task automatic wait_ir8();
    int t = 0;
    while (!ir8 && t < 200) begin @(posedge clk); #1; t++; end
    if (!ir8) timeout("wait_in_ready8");
  endtask

  task automatic wait_ov8();
    int t = 0;
    while (!ov8 && t < 200) begin @(posedge clk); #1; t++; end
    if (!ov8) timeout("wait_out_valid8");
  endtask

  task automatic do_op8(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int dly);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    wait_ir8();
    @(posedge clk); #1;
    iv8 = 1'b0;
    a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'($urandom);
    wait_ov8();
    repeat (dly) begin @(posedge clk); #1; end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic do_op1(input logic a, input logic b, input logic c);
    int t = 0;
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    while (!ir1 && t < 50) begin @(posedge clk); #1; t++; end
    if (!ir1) timeout("wait_in_ready1");
    @(posedge clk); #1;
    iv1 = 1'b0;
    t = 0;
    while (!ov1 && t < 50) begin @(posedge clk); #1; t++; end
    if (!ov1) timeout("wait_out_valid1");
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] exp_bp;
    rst = 1'b1;
    iv8 = 1'b1; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state, with in_valid high to show in_ready stays low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready8", {8'd0, ir8}, '0);
    chk("rst_out_valid8", {8'd0, ov8}, '0);
    chk("rst_busy8", {8'd0, busy8}, '0);
    chk("rst_result8", {cout8, sum8}, '0);
    chk("rst_in_ready1", {8'd0, ir1}, '0);
    iv8 = 1'b0;
    rst = 1'b0;
    #1;
    chk("in_ready8_before_edge", {8'd0, ir8}, '0);
    @(posedge clk); #1;
    chk("in_ready8_after_rst", {8'd0, ir8}, 9'd1);
    chk("in_ready1_after_rst", {8'd0, ir1}, 9'd1);

    // Directed adds from the plan; result retained in IDLE afterwards.
    do_op8(8'h3C, 8'h0F, 1'b0, 0);
    chk("hold_3C_0F", {cout8, sum8}, 9'h04B);
    do_op8(8'hFF, 8'h01, 1'b0, 1);
    chk("hold_FF_01", {cout8, sum8}, 9'h100);
    do_op8(8'hFF, 8'hFF, 1'b1, 2);
    chk("hold_FF_FF_1", {cout8, sum8}, 9'h1FF);

    // Backpressure in DONE with in_valid high and operands changing.
    a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1; iv8 = 1'b1;
    exp_bp = {1'b0, a8} + {1'b0, b8} + 9'd1;
    wait_ir8();
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_ov8();
    iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {8'd0, ov8}, 9'd1);
      chk("bp_in_ready", {8'd0, ir8}, '0);
      chk("bp_result", {cout8, sum8}, exp_bp);
      a8 = W'($urandom); b8 = W'($urandom);
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("bp_out_valid_fall", {8'd0, ov8}, '0);
    chk("bp_in_ready_back", {8'd0, ir8}, 9'd1);
    chk("bp_busy_fall", {8'd0, busy8}, '0);

    // Reset in the middle of a run (cnt=3).
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; iv8 = 1'b1;
    wait_ir8();
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_before_rst", {8'd0, busy8}, 9'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {8'd0, ov8}, '0);
    chk("midrst_busy", {8'd0, busy8}, '0);
    chk("midrst_in_ready", {8'd0, ir8}, '0);
    chk("midrst_result", {cout8, sum8}, '0);
    q8.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op8(8'h01, 8'h02, 1'b1, 0);
    chk("post_rst_result", {cout8, sum8}, 9'h004);

    // Back-to-back with in_valid held high and out_ready held high.
    or8 = 1'b1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; iv8 = 1'b1;
    wait_ir8();
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80;
    wait_ov8();
    chk("b2b_first", {cout8, sum8}, 9'h030);
    @(posedge clk); #1;
    chk("b2b_idle_ready", {8'd0, ir8}, 9'd1);
    chk("b2b_idle_valid", {8'd0, ov8}, '0);
    @(posedge clk); #1;
    chk("b2b_second_accept_busy", {8'd0, busy8}, 9'd1);
    chk("b2b_second_accept_ready", {8'd0, ir8}, '0);
    iv8 = 1'b0;
    wait_ov8();
    chk("b2b_second", {cout8, sum8}, 9'h100);
    @(posedge clk); #1;
    or8 = 1'b0;

    // Randomised operations with random consumer delay.
    for (int i = 0; i < 20; i++) begin
      do_op8(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // WIDTH=1 instance: all operand combinations, then the plan's 1+1+1 case.
    for (int i = 0; i < 8; i++) begin
      do_op1(i[0], i[1], i[2]);
    end
    chk("w1_1p1p1", {7'd0, cout1, sum1}, 9'h003);

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", (W+1)'(q8.size()), '0);
    chk("q1_drained", (W+1)'(q1.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
